// File: rtl/sprite_cmd_scheduler.sv
// sprite_cmd_scheduler: buffers host sprite commands and releases them during vblank
module sprite_cmd_scheduler #(
   parameter int FIFO_DEPTH = 64,
   parameter int VACTIVE    = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        avs_write,
   input  logic        avs_read,
   input  logic        avs_address,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   output logic [31:0] writedata,
   output logic        buffer_sel
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_VBLANK, DRAIN, FLIP} state_t;

   state_t        state;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level, remaining;
   logic [15:0]   frame_count;
   logic          overflow, commit_err;
   logic          full, push, pop, commit, clear, vblank;
   logic [31:0]   raw, head;

   assign full   = level == (AW+1)'(FIFO_DEPTH);
   assign push   = avs_write && !avs_address && !full;
   assign commit = avs_write && avs_address && avs_writedata[0];
   assign clear  = avs_write && avs_address && avs_writedata[2];
   assign vblank = hcount == 10'd0 && vcount == 10'(VACTIVE);
   // The first word leaves on the vblank edge itself, later ones from DRAIN
   assign pop    = ((state == WAIT_VBLANK && vblank) || state == DRAIN) && remaining != '0;
   assign raw    = mem[rd_ptr];
   assign head   = {raw[31:14], ~buffer_sel, raw[12:0]};

   // Command storage; pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= avs_writedata;
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         level  <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Commit / vblank / release / flip sequencing with sticky error tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         remaining   <= '0;
         writedata   <= '0;
         buffer_sel  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
         commit_err  <= 1'b0;
      end else begin
         if (clear) begin
            overflow   <= 1'b0;
            commit_err <= 1'b0;
         end
         if (avs_write && !avs_address && full) overflow <= 1'b1;
         if (commit && state != IDLE) commit_err <= 1'b1;
         case (state)
            IDLE: if (commit) begin
               remaining <= level;
               state     <= WAIT_VBLANK;
            end
            WAIT_VBLANK, DRAIN: if (state == DRAIN || vblank) begin
               if (remaining != '0) begin
                  writedata <= head;
                  remaining <= remaining - (AW+1)'(1);
                  state     <= DRAIN;
               end else begin
                  writedata   <= '0;
                  buffer_sel  <= ~buffer_sel;
                  frame_count <= frame_count + 16'd1;
                  state       <= FLIP;
               end
            end
            FLIP: state <= IDLE;
         endcase
      end
   end

   // Registered status read, held between reads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) avs_readdata <= '0;
      else if (avs_read) avs_readdata <= avs_address ? {frame_count, 4'b0, overflow, commit_err, state != IDLE, buffer_sel, 8'(level)} : 32'h0;
   end
endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// tb_sprite_cmd_scheduler: directed + randomized checks against a queue-based frame model
module tb_sprite_cmd_scheduler;
   localparam int DEPTH = 64;
   localparam int VA    = 480;

   logic        clk = 0, reset_n = 0, avs_write = 0, avs_read = 0, avs_address = 0;
   logic [31:0] avs_writedata = 0, avs_readdata, writedata;
   logic [9:0]  hcount = 5, vcount = 100;
   logic        buffer_sel;
   int          checks = 0, failures = 0;

   logic [31:0] q[$];
   bit          m_bsel, m_ovf, m_cerr, m_busy;
   logic [15:0] m_fc = 0;
   int          m_k;
   logic [31:0] w;

   always #5 clk = ~clk;

   sprite_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .VACTIVE(VA)) dut (
      .clk(clk), .reset_n(reset_n), .avs_write(avs_write), .avs_read(avs_read),
      .avs_address(avs_address), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .hcount(hcount), .vcount(vcount), .writedata(writedata), .buffer_sel(buffer_sel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      avs_write = 1; avs_address = 0; avs_writedata = d;
      if (q.size() < DEPTH) q.push_back(d); else m_ovf = 1;
      tick;
      avs_write = 0;
   endtask

   task automatic ctrl(input logic [31:0] bits);
      avs_write = 1; avs_address = 1; avs_writedata = bits;
      if (bits[2]) begin m_ovf = 0; m_cerr = 0; end
      if (bits[0]) begin
         if (m_busy) m_cerr = 1;
         else begin m_busy = 1; m_k = q.size(); end
      end
      tick;
      avs_write = 0;
   endtask

   task automatic status(input string tag);
      logic [31:0] exp;
      exp = {m_fc, 4'b0, m_ovf, m_cerr, m_busy, m_bsel, 8'(q.size())};
      avs_read = 1; avs_address = 1;
      tick;
      avs_read = 0;
      check(tag, avs_readdata, exp);
   endtask

   // Non-vblank timing positions, including near misses of the trigger point
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0: begin hcount = 10'($urandom_range(1, 799)); vcount = 10'($urandom_range(0, 524)); end
            1: begin hcount = 0; vcount = VA - 1; end
            default: begin hcount = 0; vcount = VA + 1; end
         endcase
         tick;
         check("idle_bus", writedata, 0);
      end
      hcount = 5; vcount = 100;
   endtask

   task automatic run_frame(input int push_n, input bit flip_commit);
      logic [31:0] e;
      hcount = 0; vcount = VA;
      tick;
      hcount = 5; vcount = 100;
      for (int i = 0; i < m_k; i++) begin
         if (i < push_n) begin
            avs_write = 1; avs_address = 0; avs_writedata = $urandom;
            if (q.size() < DEPTH) q.push_back(avs_writedata); else m_ovf = 1;
         end
         e = q.pop_front();
         e[13] = ~m_bsel;
         check("drain_word", writedata, e);
         tick;
         avs_write = 0;
      end
      m_bsel = ~m_bsel;
      m_fc++;
      check("post_bus", writedata, 0);
      check("buffer_sel", 32'(buffer_sel), 32'(m_bsel));
      if (flip_commit) ctrl(1); else tick;
      m_busy = 0;
   endtask

   initial begin
      repeat (2) tick;
      check("rst_bus", writedata, 0);
      check("rst_sel", 32'(buffer_sel), 0);
      check("rst_rd", avs_readdata, 0);
      reset_n = 1;
      tick;
      status("rst_status");

      push(32'h28020000); push(32'h28048123); push(32'h281E0000);
      ctrl(1);
      status("wait_busy");
      idle(6);
      run_frame(0, 0);
      status("frame1");

      push(32'h28020000); push(32'h28048123); push(32'h281E0000);
      ctrl(1);
      idle(4);
      run_frame(0, 0);
      status("frame2");

      repeat (4) begin
         repeat ($urandom_range(0, 10)) push($urandom);
         ctrl(1);
         idle($urandom_range(1, 8));
         run_frame(0, 0);
         status("rand_frame");
      end

      repeat (65) push($urandom);
      status("overflow");
      ctrl(1);
      idle(2);
      run_frame(0, 0);
      idle(5);
      status("ovf_drained");
      ctrl(4);
      status("ovf_clear");

      push($urandom); push($urandom);
      ctrl(1);
      idle(2);
      ctrl(1);
      idle(2);
      run_frame(0, 0);
      status("wait_commit_err");
      hcount = 0; vcount = VA;
      tick;
      hcount = 5; vcount = 100;
      idle(4);
      check("no_flip", 32'(buffer_sel), 32'(m_bsel));
      status("no_flip_status");
      ctrl(4);

      repeat (4) push($urandom);
      ctrl(1);
      idle(3);
      run_frame(2, 0);
      status("drain_push");
      ctrl(1);
      idle(2);
      run_frame(0, 1);
      status("flip_commit");
      ctrl(1);
      status("idle_commit");
      run_frame(0, 0);
      status("empty_frame");
      ctrl(4);

      repeat (5) push($urandom);
      ctrl(1);
      idle(2);
      hcount = 0; vcount = VA;
      tick;
      hcount = 5; vcount = 100;
      w = q[0]; w[13] = ~m_bsel;
      check("md_word1", writedata, w);
      tick;
      w = q[1]; w[13] = ~m_bsel;
      check("md_word2", writedata, w);
      #2 reset_n = 0;
      #1;
      check("md_bus", writedata, 0);
      check("md_sel", 32'(buffer_sel), 0);
      check("md_rd", avs_readdata, 0);
      q.delete();
      m_bsel = 0; m_ovf = 0; m_cerr = 0; m_busy = 0; m_fc = 0;
      @(negedge clk);
      reset_n = 1;
      tick;
      status("md_status");
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
